// File: rtl/spi_mem_ctrl.sv
// rtl/spi_mem_ctrl.sv - SPI command sequencer to a req/ack memory with a one-deep command buffer.
// Optional feature: define SPI_MEM_AUTO_INC_EN to post-increment addresses on each completed access.
module spi_mem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, RD_RET} state_t;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_READ    = 2'b11;

  state_t state, state_n;

  logic              buf_valid, buf_valid_n;
  logic [9:0]        buf_data, buf_data_n;
  logic [ADDR_W-1:0] wr_addr, wr_addr_n, rd_addr, rd_addr_n;
  logic              wr_addr_ok, wr_addr_ok_n, rd_addr_ok, rd_addr_ok_n;

  logic [7:0]        tx_data_n;
  logic              tx_valid_n, mem_req_n, mem_we_n, busy_n, err_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n;

  // Command evaluated this cycle: the buffered word wins over a fresh rx word.
  logic       cmd_valid;
  logic [9:0] cmd;
  logic [1:0] op;
  logic       wr_go, rd_go, seq_err, overflow;

  assign cmd_valid = (state == IDLE) && (buf_valid || rx_valid);
  assign cmd       = buf_valid ? buf_data : rx_data;
  assign op        = cmd[9:8];
  assign wr_go     = cmd_valid && (op == OP_WRITE) && wr_addr_ok;
  assign rd_go     = cmd_valid && (op == OP_READ) && rd_addr_ok;
  assign seq_err   = cmd_valid && (((op == OP_WRITE) && !wr_addr_ok) ||
                                   ((op == OP_READ) && !rd_addr_ok));
  assign overflow  = (state != IDLE) && rx_valid && buf_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE: begin
        if (wr_go)      state_n = WR_REQ;
        else if (rd_go) state_n = RD_REQ;
        else            state_n = IDLE;
      end
      WR_REQ:  state_n = mem_ack ? IDLE : WR_REQ;
      RD_REQ:  state_n = mem_ack ? RD_RET : RD_REQ;
      RD_RET:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    buf_valid_n  = buf_valid;
    buf_data_n   = buf_data;
    wr_addr_n    = wr_addr;
    rd_addr_n    = rd_addr;
    wr_addr_ok_n = wr_addr_ok;
    rd_addr_ok_n = rd_addr_ok;
    tx_data_n    = tx_data;
    tx_valid_n   = 1'b0;
    mem_req_n    = mem_req;
    mem_we_n     = mem_we;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;
    err_n        = seq_err || overflow;

    // In IDLE the buffer drains and a simultaneous rx word takes its place.
    if (state == IDLE) begin
      if (buf_valid) begin
        buf_valid_n = rx_valid;
        if (rx_valid) buf_data_n = rx_data;
      end
    end else if (rx_valid && !buf_valid) begin
      buf_valid_n = 1'b1;
      buf_data_n  = rx_data;
    end

    if (cmd_valid && (op == OP_WR_ADDR)) begin
      wr_addr_n    = cmd[ADDR_W-1:0];
      wr_addr_ok_n = 1'b1;
    end
    if (cmd_valid && (op == OP_RD_ADDR)) begin
      rd_addr_n    = cmd[ADDR_W-1:0];
      rd_addr_ok_n = 1'b1;
    end

    if (wr_go) begin
      mem_req_n   = 1'b1;
      mem_we_n    = 1'b1;
      mem_addr_n  = wr_addr;
      mem_wdata_n = cmd[DATA_W-1:0];
    end
    if (rd_go) begin
      mem_req_n  = 1'b1;
      mem_we_n   = 1'b0;
      mem_addr_n = rd_addr;
    end

    if ((state == WR_REQ) && mem_ack) begin
      mem_req_n = 1'b0;
      mem_we_n  = 1'b0;
`ifdef SPI_MEM_AUTO_INC_EN
      wr_addr_n = wr_addr + 1'b1;
`endif
    end
    if ((state == RD_REQ) && mem_ack) begin
      mem_req_n  = 1'b0;
      tx_data_n  = mem_rdata;
      tx_valid_n = 1'b1;
`ifdef SPI_MEM_AUTO_INC_EN
      rd_addr_n  = rd_addr + 1'b1;
`endif
    end

    busy_n = (state_n != IDLE) || buf_valid_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid  <= 1'b0;
      buf_data   <= '0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      wr_addr_ok <= 1'b0;
      rd_addr_ok <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      buf_valid  <= buf_valid_n;
      buf_data   <= buf_data_n;
      wr_addr    <= wr_addr_n;
      rd_addr    <= rd_addr_n;
      wr_addr_ok <= wr_addr_ok_n;
      rd_addr_ok <= rd_addr_ok_n;
      tx_data    <= tx_data_n;
      tx_valid   <= tx_valid_n;
      mem_req    <= mem_req_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      busy       <= busy_n;
      err        <= err_n;
    end
  end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb/tb_spi_mem_ctrl.sv - scoreboard bench for spi_mem_ctrl with a wait-state memory model.
module tb_spi_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = '0;
  logic       busy, err;

`ifdef SPI_MEM_AUTO_INC_EN
  localparam logic [7:0] AI = 8'd1;
`else
  localparam logic [7:0] AI = 8'd0;
`endif

  spi_mem_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         len;
  } acc_t;

  acc_t       exp_acc[$];
  logic [7:0] exp_tx[$];
  int         exp_err[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  // Memory model: acks after ack_wait wait states, services reads/writes on ack.
  logic [7:0] mem_model [256];
  int ack_wait = 0;
  int wcnt = 0;
  initial for (int i = 0; i < 256; i++) mem_model[i] = pat(8'(i));

  always @(negedge clk) begin
    if (mem_ack) mem_ack = 1'b0;
    else if (mem_req) begin
      if (wcnt >= ack_wait) begin
        mem_ack = 1'b1;
        if (mem_we) mem_model[mem_addr] = mem_wdata;
        else        mem_rdata = mem_model[mem_addr];
        wcnt = 0;
      end else wcnt++;
    end else wcnt = 0;
  end

  logic last_edge_ack = 1'b0;
  always @(posedge clk) last_edge_ack = mem_ack;

  // Monitor: pops expectations whenever the DUT presents an access, a read byte or an error.
  acc_t cur;
  int   run = 0;
  logic last_req = 1'b0;
  always @(negedge clk) begin
    if (mem_req && !last_req) begin
      chk("acc_expected", exp_acc.size() != 0, 1);
      if (exp_acc.size() != 0) begin
        cur = exp_acc.pop_front();
        chk("acc_we", mem_we, cur.we);
        chk("acc_addr", mem_addr, cur.addr);
        if (cur.we) chk("acc_wdata", mem_wdata, cur.wdata);
      end
      run = 1;
    end else if (mem_req) begin
      run++;
      chk("acc_addr_stable", mem_addr, cur.addr);
      chk("acc_we_stable", mem_we, cur.we);
      if (cur.we) chk("acc_wdata_stable", mem_wdata, cur.wdata);
    end else if (last_req && cur.len >= 0) begin
      chk("acc_req_cycles", run, cur.len);
    end
    last_req = mem_req;

    if (tx_valid) begin
      chk("tx_expected", exp_tx.size() != 0, 1);
      chk("tx_after_ack", last_edge_ack, 1);
      if (exp_tx.size() != 0) chk("tx_data", tx_data, exp_tx.pop_front());
    end

    if (err) begin
      chk("err_expected", exp_err.size() != 0, 1);
      if (exp_err.size() != 0) void'(exp_err.pop_front());
    end
  end

  task automatic send(input logic [9:0] w);
    rx_data  = w;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic push_acc(input logic we, input logic [7:0] a, input logic [7:0] d, input int len);
    acc_t e;
    e.we = we; e.addr = a; e.wdata = d; e.len = len;
    exp_acc.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    logic done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = !busy && !mem_req && (exp_acc.size() == 0) && (exp_tx.size() == 0) &&
             (exp_err.size() == 0);
    end
    chk(name, done, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string name);
    chk({name, "_tx_data"}, tx_data, 0);
    chk({name, "_tx_valid"}, tx_valid, 0);
    chk({name, "_mem_req"}, mem_req, 0);
    chk({name, "_mem_we"}, mem_we, 0);
    chk({name, "_mem_addr"}, mem_addr, 0);
    chk({name, "_mem_wdata"}, mem_wdata, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_err"}, err, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Write then read back, zero wait states
    ack_wait = 0;
    send(10'h012);
    push_acc(1'b1, 8'h12, 8'hA5, 1);
    send(10'h1A5);
    wait_idle("drain_wr");
    push_acc(1'b0, 8'h12, 8'h00, 1);
    exp_tx.push_back(8'hA5);
    send(10'h212);
    send(10'h300);
    wait_idle("drain_rd");

    // Five wait states
    ack_wait = 5;
    send(10'h05A);
    push_acc(1'b1, 8'h5A, 8'h3C, 6);
    send(10'h13C);
    wait_idle("drain_ws_wr");
    push_acc(1'b0, 8'h5A, 8'h00, 6);
    exp_tx.push_back(8'h3C);
    send(10'h25A);
    send(10'h3FF);
    wait_idle("drain_ws_rd");

    // Sequence errors straight after reset
    do_reset();
    exp_err.push_back(1);
    exp_err.push_back(2);
    send(10'h1FF);
    send(10'h300);
    wait_idle("drain_seq_err");

    // Buffering and overflow while a write is held off
    ack_wait = 6;
    send(10'h020);
    send(10'h221);
    wait_idle("drain_buf_setup");
    push_acc(1'b1, 8'h20, 8'h77, 7);
    push_acc(1'b0, 8'h21, 8'h00, 7);
    exp_tx.push_back(pat(8'h21));
    exp_err.push_back(3);
    send(10'h177);
    send(10'h3AA);
    send(10'h2EE);
    chk("busy_while_buffered", busy, 1);
    wait_idle("drain_buf");
    push_acc(1'b0, 8'h21 + AI, 8'h00, 7);
    exp_tx.push_back(pat(8'h21 + AI));
    send(10'h300);
    wait_idle("drain_after_ovf");

    // Reset while a read is outstanding
    ack_wait = 30;
    send(10'h240);
    push_acc(1'b0, 8'h40, 8'h00, -1);
    send(10'h300);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        seen = mem_req;
      end
      chk("req_before_reset", seen, 1);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_zero("midreset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_err.push_back(4);
    send(10'h300);
    wait_idle("drain_midreset");

    // Address wrap across two writes
    ack_wait = 0;
    send(10'h0FF);
    push_acc(1'b1, 8'hFF, 8'h11, 1);
    send(10'h111);
    wait_idle("drain_wrap1");
    push_acc(1'b1, 8'hFF + AI, 8'h22, 1);
    send(10'h122);
    wait_idle("drain_wrap2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
